lamp_guard: RTL and testbench
=============================

# lamp_guard

Safety stage directly downstream of the traffic-light controller `top`. It consumes the controller's `red_on`/`yellow_on`/`green_on` and drives the physical lamp outputs. It checks every sample for illegal aspects. On any violation it latches a fault code, never drives the offending aspect, and forces flashing red until an operator clears the fault while the controller shows red.

## Interface
Parameters:
- `DARK_LIMIT`, default 8: number of consecutive all-off samples, after arming, that raises a dark fault (legal range 2..255).
- `FLASH_HALF`, default 4: length in cycles of each on phase and each off phase of the fail-safe red flash (≥1).

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `red_on` input 1: red request from the controller.
- `yellow_on` input 1: yellow request from the controller.
- `green_on` input 1: green request from the controller.
- `clear_fault` input 1: operator clear, level-sampled.
- `red_lamp` output 1: registered red lamp drive.
- `yellow_lamp` output 1: registered yellow lamp drive.
- `green_lamp` output 1: registered green lamp drive.
- `fault` output 1: registered; high while in FAULT.
- `fault_code` output 2: registered. 0 = none, 1 = overlap, 2 = dark, 3 = green→red skip.

## Operation
- Input stage: the three requests are registered into sample `s`, one cycle after the input edge.
- Sample classes:
  - dark: no bit set.
  - single: exactly one bit set.
  - overlap: two or more bits set.
- Arming: `armed` sets on the first non-dark sample after reset. The dark counter runs only while `armed`=1.
- `last`: the most recent non-dark single sample, held across dark gaps. Reset value is none.
- Checks, evaluated on `s` in NORMAL:
  - Overlap → code 1.
  - Skip: `last`=green-only and `s`=red-only → code 3.
  - Dark: `armed`=1 and the dark counter reaches `DARK_LIMIT` on this sample → code 2.
  - Priority when several are true together: 1 > 3 > 2.
- States:
  - NORMAL, no violation: lamps ← `s`; `fault`=0; `fault_code`=0. A dark sample below the limit drives all lamps 0.
  - NORMAL, violation: go to FAULT, latch the code, set `fault`=1, `red_lamp`=1, yellow and green lamps 0. The violating sample is never driven onto the lamps.
  - FAULT: yellow and green lamps 0. `red_lamp` holds 1 for `FLASH_HALF` cycles, then 0 for `FLASH_HALF` cycles, repeating. New violations are ignored; the first latched code holds.
  - FAULT → NORMAL: `clear_fault`=1 and `s`=red-only. The next edge sets `fault`=0, `fault_code`=0, `red_lamp`=1, and restarts the flash counter.
  - `clear_fault` asserted with any other `s` is ignored. `clear_fault` in NORMAL is ignored.
- On clear, `last` is set to red, the dark counter to 0, and `armed` to 1.
- Dark counter: 8 bits, saturating. Cleared by any non-dark sample.
- Flash counter: `$clog2(FLASH_HALF)+1` bits, wraps at `FLASH_HALF`-1.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - all lamps 0, `fault`=0, `fault_code`=0;
  - state NORMAL, `armed`=0, `last`=none, `s`=0, all counters 0.
- Reset mid-FAULT or mid-sequence returns to exactly this state; nothing persists.
- Latency: an input change at edge k is seen in `s` at k+1 and drives the lamps (or `fault`) at k+2.
- Dark fault: `fault` rises 2 cycles after the input edge that starts the `DARK_LIMIT`-th consecutive dark sample.
- Recovery: `clear_fault` and red input at edge k give `fault`=0 at k+2, provided `clear_fault` is still 1 at k+1.

## Configuration
- `LAMP_GUARD_SKIP_CHECK_EN` defined: the green→red skip check (code 3) is compiled in.
- Undefined: the skip check is absent. A green→red transition passes through as a normal aspect change, and code 3 is never produced.

## Test plan
- Reset held mid-sequence, then released with red_on=1: lamps 0 and fault 0 during reset; red_lamp=1 two cycles after release; fault stays 0.
- Legal cycle red(10)→green(10)→yellow(5)→red: each lamp follows its input delayed by exactly 2 cycles; fault=0 throughout.
- red_on and green_on both 1 for one cycle: fault=1 and fault_code=1 two cycles later; green_lamp never 1; red_lamp shows 4 cycles on, 4 cycles off, repeating.
- After arming, inputs dark for 7 cycles then red: no fault. Inputs dark for 8 cycles: fault_code=2.
- green→red with no yellow: with the macro defined, fault_code=3; with it undefined, red_lamp=1 and fault=0.
- In FAULT, clear_fault=1 with green_on=1: fault stays 1. Then red_on=1 with clear_fault=1: fault=0 and fault_code=0 at k+2, and lamps follow their inputs again.

Source files
------------

// File: rtl/lamp_guard.sv
// lamp_guard: safety stage between the traffic-light controller and the
// physical lamps. It registers the controller's lamp requests, rejects
// illegal aspects (overlap, prolonged dark, optional green-to-red skip),
// and on any violation latches a fault code and flashes red until an
// operator clears the fault while the controller requests red only.
//
// Optional feature: define LAMP_GUARD_SKIP_CHECK_EN to compile in the
// green-to-red skip check (fault code 3). Without it, green-to-red passes
// through as an ordinary aspect change.
//
// Parameters:
//   DARK_LIMIT  consecutive armed all-off samples that raise a dark fault (2..255)
//   FLASH_HALF  cycles per on phase and per off phase of the fault flash (>=1)
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   red_on       red request from the controller
//   yellow_on    yellow request from the controller
//   green_on     green request from the controller
//   clear_fault  operator clear, level-sampled
//   red_lamp     registered red lamp drive
//   yellow_lamp  registered yellow lamp drive
//   green_lamp   registered green lamp drive
//   fault        registered, high while in FAULT
//   fault_code   registered: 0 none, 1 overlap, 2 dark, 3 green-to-red skip

`timescale 1ns/1ps

module lamp_guard #(
  parameter int DARK_LIMIT = 8,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       red_on,
  input  logic       yellow_on,
  input  logic       green_on,
  input  logic       clear_fault,
  output logic       red_lamp,
  output logic       yellow_lamp,
  output logic       green_lamp,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int              FW        = $clog2(FLASH_HALF) + 1;
  localparam logic [FW-1:0]   FLASH_MAX = FW'(FLASH_HALF - 1);
  localparam logic [7:0]      DARK_MAX  = 8'(DARK_LIMIT);

  // Sample encoding is {red, yellow, green}.
  localparam logic [2:0] RED_ONLY    = 3'b100;
  localparam logic [2:0] YELLOW_ONLY = 3'b010;
  localparam logic [2:0] GREEN_ONLY  = 3'b001;

  typedef enum logic {
    NORMAL,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    LAST_NONE,
    LAST_RED,
    LAST_YELLOW,
    LAST_GREEN
  } last_t;

  state_t        state;
  last_t         last;
  logic [2:0]    s;
  logic          armed;
  logic [7:0]    dark_cnt;
  logic [FW-1:0] flash_cnt;

  logic          is_dark;
  logic          is_single;
  logic          is_overlap;
  logic          skip_hit;
  logic          dark_hit;
  logic [7:0]    dark_next;
  logic [1:0]    viol_code;
  last_t         last_next;

  // Classify the current sample and work out which violation (if any) it
  // represents. The dark count used for the check already includes this
  // sample, so the fault fires on the DARK_LIMIT-th dark sample itself.
  always_comb begin
    is_dark    = (s == 3'b000);
    is_single  = (s == RED_ONLY) || (s == YELLOW_ONLY) || (s == GREEN_ONLY);
    is_overlap = !is_dark && !is_single;

    dark_next = 8'd0;
    if (is_dark) begin
      if (armed && (dark_cnt != 8'hFF)) begin
        dark_next = dark_cnt + 8'd1;
      end else begin
        dark_next = dark_cnt;
      end
    end

    dark_hit = armed && is_dark && (dark_next == DARK_MAX);

`ifdef LAMP_GUARD_SKIP_CHECK_EN
    skip_hit = (last == LAST_GREEN) && (s == RED_ONLY);
`else
    skip_hit = 1'b0;
`endif

    // Overlap outranks skip, which outranks dark.
    if (is_overlap) begin
      viol_code = 2'd1;
    end else if (skip_hit) begin
      viol_code = 2'd3;
    end else if (dark_hit) begin
      viol_code = 2'd2;
    end else begin
      viol_code = 2'd0;
    end

    // Only a clean single aspect updates the history; dark gaps hold it.
    case (s)
      RED_ONLY:    last_next = LAST_RED;
      YELLOW_ONLY: last_next = LAST_YELLOW;
      GREEN_ONLY:  last_next = LAST_GREEN;
      default:     last_next = last;
    endcase
  end

  // Guard FSM. Every output is registered here. In FAULT the red lamp
  // toggles each time the flash counter wraps, giving FLASH_HALF cycles on
  // followed by FLASH_HALF cycles off, starting with the on phase at entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NORMAL;
      last        <= LAST_NONE;
      s           <= 3'b000;
      armed       <= 1'b0;
      dark_cnt    <= 8'd0;
      flash_cnt   <= '0;
      red_lamp    <= 1'b0;
      yellow_lamp <= 1'b0;
      green_lamp  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'd0;
    end else begin
      s <= {red_on, yellow_on, green_on};
      case (state)
        NORMAL: begin
          dark_cnt <= dark_next;
          last     <= last_next;
          if (!is_dark) begin
            armed <= 1'b1;
          end
          if (viol_code != 2'd0) begin
            // The offending sample never reaches the lamps.
            state       <= FAULT;
            fault       <= 1'b1;
            fault_code  <= viol_code;
            red_lamp    <= 1'b1;
            yellow_lamp <= 1'b0;
            green_lamp  <= 1'b0;
            flash_cnt   <= '0;
          end else begin
            red_lamp    <= s[2];
            yellow_lamp <= s[1];
            green_lamp  <= s[0];
            fault       <= 1'b0;
            fault_code  <= 2'd0;
          end
        end
        FAULT: begin
          yellow_lamp <= 1'b0;
          green_lamp  <= 1'b0;
          if (clear_fault && (s == RED_ONLY)) begin
            // Resume as if a clean red had just been shown.
            state      <= NORMAL;
            fault      <= 1'b0;
            fault_code <= 2'd0;
            red_lamp   <= 1'b1;
            flash_cnt  <= '0;
            last       <= LAST_RED;
            dark_cnt   <= 8'd0;
            armed      <= 1'b1;
          end else if (flash_cnt == FLASH_MAX) begin
            flash_cnt <= '0;
            red_lamp  <= ~red_lamp;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
        default: begin
          state <= NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_guard.sv
// tb_lamp_guard: self-checking bench for lamp_guard. A directed vector table
// walks a legal cycle, an overlap fault with rejected and accepted clears;
// hand sequences cover dark limits, flash timing, reset mid-fault and the
// green-to-red skip; a randomized phase compares against a cycle model built
// from the aspect rules (run lengths, time since fault entry).

`timescale 1ns/1ps

module tb_lamp_guard;

  localparam int DL = 8;
  localparam int FH = 4;

`ifdef LAMP_GUARD_SKIP_CHECK_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       red_on;
  logic       yellow_on;
  logic       green_on;
  logic       clear_fault;
  logic       red_lamp;
  logic       yellow_lamp;
  logic       green_lamp;
  logic       fault;
  logic [1:0] fault_code;

  int n_compared;
  int n_mismatched;

  lamp_guard #(
    .DARK_LIMIT(DL),
    .FLASH_HALF(FH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .red_on     (red_on),
    .yellow_on  (yellow_on),
    .green_on   (green_on),
    .clear_fault(clear_fault),
    .red_lamp   (red_lamp),
    .yellow_lamp(yellow_lamp),
    .green_lamp (green_lamp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed bundle order: {red, yellow, green, fault, code[1:0]}
  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {red_lamp, yellow_lamp, green_lamp, fault, fault_code};
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b expected %b (r y g fault code)", name, obs, exp);
    end
  endtask

  // Drive one input set, let one rising edge take it, sample 1ns later.
  task automatic applyStimulus(input logic r, input logic y, input logic g, input logic c);
    red_on      = r;
    yellow_on   = y;
    green_on    = g;
    clear_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    red_on      = 1'b0;
    yellow_on   = 1'b0;
    green_on    = 1'b0;
    clear_fault = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Reference model: aspects as integers (0 none, 1 red, 2 yellow, 3 green),
  // dark run length, and fault age counted from the entry edge.
  logic [2:0] m_s;
  bit         m_armed;
  int         m_last;
  int         m_dark;
  bit         m_fault;
  int         m_code;
  int         m_age;
  logic [5:0] m_exp;

  task automatic modelReset();
    m_s     = 3'b000;
    m_armed = 1'b0;
    m_last  = 0;
    m_dark  = 0;
    m_fault = 1'b0;
    m_code  = 0;
    m_age   = 0;
    m_exp   = 6'b000000;
  endtask

  task automatic modelStep(input logic r, input logic y, input logic g, input logic c);
    int pop;
    int aspect;
    int run;
    int code;
    pop    = int'(m_s[2]) + int'(m_s[1]) + int'(m_s[0]);
    aspect = m_s[2] ? 1 : (m_s[1] ? 2 : (m_s[0] ? 3 : 0));
    if (!m_fault) begin
      code = 0;
      run  = m_dark;
      if (pop != 0) run = 0;
      else if (m_armed && run < 255) run = run + 1;
      if (pop >= 2) code = 1;
      else if (SKIP_EN && pop == 1 && m_last == 3 && aspect == 1) code = 3;
      else if (m_armed && pop == 0 && run == DL) code = 2;
      m_dark = run;
      if (pop != 0) m_armed = 1'b1;
      if (pop == 1) m_last = aspect;
      if (code != 0) begin
        m_fault = 1'b1;
        m_code  = code;
        m_age   = 0;
        m_exp   = {3'b100, 1'b1, 2'(code)};
      end else begin
        m_exp = {m_s, 3'b000};
      end
    end else begin
      if (c && pop == 1 && aspect == 1) begin
        m_fault = 1'b0;
        m_code  = 0;
        m_last  = 1;
        m_dark  = 0;
        m_armed = 1'b1;
        m_exp   = 6'b100000;
      end else begin
        m_age = m_age + 1;
        m_exp = {(((m_age / FH) % 2) == 0), 2'b00, 1'b1, 2'(m_code)};
      end
    end
    m_s = {r, y, g};
  endtask

  typedef struct packed {
    logic [3:0] stim;   // {r, y, g, clear}
    logic [5:0] exp;    // {r, y, g, fault, code} after this edge
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [2:0] ovl [4];
    logic [2:0] pat;
    logic       clr;
    int         kind;
    int         hold;
    int         cyc;

    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b0;
    red_on       = 1'b0;
    yellow_on    = 1'b0;
    green_on     = 1'b0;
    clear_fault  = 1'b0;

    vecs = '{
      '{4'b1000, 6'b000000},
      '{4'b1000, 6'b100000},
      '{4'b0010, 6'b100000},
      '{4'b0010, 6'b001000},
      '{4'b0100, 6'b001000},
      '{4'b1000, 6'b010000},
      '{4'b1010, 6'b100000},
      '{4'b0010, 6'b100101},
      '{4'b0011, 6'b100101},
      '{4'b0011, 6'b100101},
      '{4'b1001, 6'b100101},
      '{4'b1001, 6'b100000},
      '{4'b0010, 6'b100000},
      '{4'b0010, 6'b001000},
      '{4'b0100, 6'b001000},
      '{4'b0000, 6'b010000},
      '{4'b0000, 6'b000000}
    };

    $display("[TB] start");
    doReset();
    checkOutput("reset_state", 6'b000000);

    // Directed table: legal cycle, overlap fault, clear attempts.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].stim[3], vecs[i].stim[2], vecs[i].stim[1], vecs[i].stim[0]);
      checkOutput($sformatf("table[%0d]", i), vecs[i].exp);
    end

    // Dark: 7 armed dark samples are tolerated, the 8th faults.
    doReset();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("dark_arm", 6'b100000);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("dark7[%0d]", i), (i == 0) ? 6'b100000 : 6'b000000);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("dark7_end", 6'b000000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("dark7_red", 6'b100000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("dark8[%0d]", i), (i == 0) ? 6'b100000 : 6'b000000);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("dark_fault", 6'b100110);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("flash[%0d]", i), {(((i / FH) % 2) == 0), 5'b00110});
    end

    // Reset asserted while in FAULT, released with red requested.
    red_on  = 1'b1;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_async", 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", 6'b000000);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_reset_1", 6'b000000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_reset_2", 6'b100000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_reset_3", 6'b100000);

    // Green straight to red.
    doReset();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("skip_green", 6'b001000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("skip_pre", 6'b001000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("skip_edge", SKIP_EN ? 6'b100111 : 6'b100000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("skip_after", SKIP_EN ? 6'b100111 : 6'b100000);

    // Randomized segments against the reference model.
    ovl = '{3'b110, 3'b101, 3'b011, 3'b111};
    doReset();
    modelReset();
    cyc = 0;
    while (cyc < 1500) begin
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 12));
      case (kind)
        0, 1, 2, 8, 9: pat = 3'b100;
        3:             pat = 3'b010;
        4, 5:          pat = 3'b001;
        6:             pat = 3'b000;
        default:       pat = ovl[$urandom_range(0, 3)];
      endcase
      if (kind == 7) hold = 1;
      for (int j = 0; j < hold; j++) begin
        clr = ($urandom_range(0, 3) == 0);
        modelStep(pat[2], pat[1], pat[0], clr);
        applyStimulus(pat[2], pat[1], pat[0], clr);
        checkOutput($sformatf("random[%0d]", cyc), m_exp);
        cyc++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
